// File: rtl/ifetch_queue_ctrl.sv
// Fetch-side controller: owns the PC, issues dual-word IMEM reads and queues instruction pairs for decode.
// Vectors are [WORD-1:0]; MSB-first bit k of the pair-address description is bit WORD-1-k here.
module ifetch_queue_ctrl #(
    parameter int              WORD  = 32,
    parameter int              DEPTH = 4,
    parameter logic [WORD-1:0] NOP   = WORD'(32'h0020_0000)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stop_and_signal,
    input  logic            branch_taken,
    input  logic [WORD-1:0] BTA,
    output logic            imem_rd_en,
    output logic [WORD-1:0] imem_addr,
    input  logic [WORD-1:0] imem_data1,
    input  logic [WORD-1:0] imem_data2,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [WORD-1:0] dec_instr1,
    output logic [WORD-1:0] dec_instr2,
    output logic [WORD-1:0] dec_pc,
    output logic [WORD-1:0] fetch_pc,
    output logic            halted
);

    // state | meaning
    // RUN   | fetching and delivering pairs to decode
    // HALT  | stopped after stop_and_signal; left only by reset
    typedef enum logic {RUN, HALT} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t          state_q, state_d;
    logic [WORD-1:0] pc_q;
    logic            inflight_q;
    logic            inflight_odd_q;
    logic [WORD-1:0] inflight_base_q;

    logic [WORD-1:0] q_instr1 [DEPTH];
    logic [WORD-1:0] q_instr2 [DEPTH];
    logic [WORD-1:0] q_pc     [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic            issue, flush, push, pop;
    logic [CW-1:0]   credit;

    logic unused_bta;
    assign unused_bta = ^BTA[1:0];

    // The in-flight read holds a slot so a response always has room.
    assign credit = count + CW'(inflight_q);

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        flush     = 1'b0;
        dec_valid = 1'b0;
        case (state_q)
            RUN: begin
                if (stop_and_signal) begin
                    state_d = HALT;
                end else begin
                    dec_valid = (count != '0);
                    if (branch_taken) begin
                        flush = 1'b1;
                    end else if (credit < CW'(DEPTH)) begin
                        issue = 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (reset) begin
            issue = 1'b0;
        end
    end

    assign imem_rd_en = issue;
    assign imem_addr  = {pc_q[WORD-1:3], 3'b000};
    assign pop        = dec_valid && dec_ready;
    // A response landing in the branch cycle belongs to the old stream.
    assign push       = inflight_q && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RUN;
            pc_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_odd_q  <= 1'b0;
            inflight_base_q <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr1[i] <= '0;
                q_instr2[i] <= '0;
                q_pc[i]     <= '0;
            end
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_odd_q  <= pc_q[2];
                inflight_base_q <= imem_addr;
            end

            if (flush) begin
                pc_q <= {BTA[WORD-1:2], 2'b00};
            end else if (issue) begin
                pc_q <= pc_q + (pc_q[2] ? WORD'(4) : WORD'(8));
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    q_instr1[wr_ptr] <= inflight_odd_q ? NOP : imem_data1;
                    q_instr2[wr_ptr] <= imem_data2;
                    q_pc[wr_ptr]     <= inflight_base_q;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign dec_instr1 = q_instr1[rd_ptr];
    assign dec_instr2 = q_instr2[rd_ptr];
    assign dec_pc     = q_pc[rd_ptr];
    assign fetch_pc   = pc_q;
    assign halted     = (state_q == HALT);

endmodule
